// File: rtl/world_if_gen.sv
// world_if_gen: PicoBlaze register interface for the Rojobot world.
// Holding registers are written by the PicoBlaze and copied, in two groups,
// into the system registers seen by the application. The block also carries
// an acknowledged update request with an overrun counter and a heartbeat watchdog.
module world_if_gen #(
    parameter int unsigned DW       = 8,
    parameter int unsigned NREG     = 6,
    parameter int unsigned NSYS     = 4,
    parameter int unsigned WDOG_CYC = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Wr_Strobe,
    input  logic             Rd_Strobe,
    input  logic [7:0]       AddrIn,
    input  logic [DW-1:0]    DataIn,
    output logic [DW-1:0]    DataOut,
    input  logic [DW-1:0]    MotCtl,
    input  logic [DW-1:0]    BotConfig,
    output logic [NREG*DW-1:0] SysRegs,
    output logic [DW-1:0]    MapX,
    output logic [DW-1:0]    MapY,
    input  logic [1:0]       MapVal,
    output logic             upd_sysregs,
    input  logic             upd_ack,
    output logic             bot_running
);

    localparam int unsigned WW = $clog2(WDOG_CYC);

    typedef enum logic {StIdle, StPend} state_t;

    logic [4:0]    addr;
    logic          ld_sys, ld_dist, upd_wr, ovr_wr, hb_wr;
    logic [DW-1:0] hold_q [NREG];
    logic [DW-1:0] sys_q  [NREG];
    logic [DW-1:0] map_x_q, map_y_q;
    logic [DW-1:0] rd_data, data_out_q;
    logic [DW-1:0] ovr_q, ovr_d;
    logic [WW-1:0] wdog_q, wdog_d;
    state_t        state_q, state_d;

    // Read strobe has no side effects; upper address bits alias.
    logic unused_bits;
    assign unused_bits = ^{Rd_Strobe, AddrIn[7:5]};

    assign addr    = AddrIn[4:0];
    assign ld_sys  = Wr_Strobe && (addr == 5'h18);
    assign ld_dist = Wr_Strobe && (addr == 5'h19);
    assign upd_wr  = Wr_Strobe && (addr == 5'h1A);
    assign ovr_wr  = Wr_Strobe && (addr == 5'h1B);
    assign hb_wr   = Wr_Strobe && (addr == 5'h1C);

    assign upd_sysregs = (state_q == StPend);
    assign bot_running = (wdog_q != '0) || hb_wr;
    assign MapX        = map_x_q;
    assign MapY        = map_y_q;
    assign DataOut     = data_out_q;

    // Holding registers (port A-1) and the two-group copy into system registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                hold_q[i] <= '0;
                sys_q[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (Wr_Strobe && (addr == 5'(i + 1))) hold_q[i] <= DataIn;
                if ((i < NSYS) ? ld_sys : ld_dist) sys_q[i] <= hold_q[i];
            end
        end
    end

    // Flatten system registers onto the output bus, register 0 in the low bits
    always_comb begin
        SysRegs = '0;
        for (int unsigned i = 0; i < NREG; i++) SysRegs[i*DW +: DW] = sys_q[i];
    end

    // Map address registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            map_x_q <= '0;
            map_y_q <= '0;
        end else if (Wr_Strobe) begin
            if (addr == 5'h10) map_x_q <= DataIn;
            if (addr == 5'h11) map_y_q <= DataIn;
        end
    end

    // Read decode; unmapped addresses return zero
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (addr == 5'(i + 1)) rd_data = hold_q[i];
        end
        case (addr)
            5'h00:   rd_data = MotCtl;
            5'h10:   rd_data = map_x_q;
            5'h11:   rd_data = map_y_q;
            5'h12:   rd_data[1:0] = MapVal;
            5'h13:   rd_data = BotConfig;
            5'h1A:   rd_data[0] = upd_sysregs;
            5'h1B:   rd_data = ovr_q;
            5'h1C:   rd_data[0] = bot_running;
            default: ;
        endcase
    end

    // Registered read data, one cycle behind AddrIn
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_out_q <= '0;
        else       data_out_q <= rd_data;
    end

    // Update request FSM and overrun counter next-state
    always_comb begin
        state_d = state_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            StIdle: if (upd_wr) state_d = StPend;
            StPend: begin
                if (upd_ack && !upd_wr) begin
                    state_d = StIdle;
                end else if (upd_wr && !upd_ack && (ovr_q != {DW{1'b1}})) begin
                    ovr_d = ovr_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Clearing wins over a same-cycle increment
        if (ovr_wr) ovr_d = '0;
    end

    // Update request state and overrun counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
        end
    end

    // Watchdog next-state: reload on heartbeat, else count down and stick at zero
    always_comb begin
        wdog_d = wdog_q;
        if (hb_wr)              wdog_d = WW'(WDOG_CYC - 1);
        else if (wdog_q != '0)  wdog_d = wdog_q - 1'b1;
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end

endmodule

// File: tb/tb_world_if_gen.sv
// Self-checking bench for world_if_gen: scoreboarded register reads plus
// direct checks of system registers, update request and watchdog.
module tb_world_if_gen;

    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 6;
    localparam int unsigned NSYS = 4;
    localparam int unsigned WDOG = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               Wr_Strobe = 1'b0;
    logic               Rd_Strobe = 1'b0;
    logic [7:0]         AddrIn = '0;
    logic [DW-1:0]      DataIn = '0;
    logic [DW-1:0]      DataOut;
    logic [DW-1:0]      MotCtl = 8'h5A;
    logic [DW-1:0]      BotConfig = 8'hC3;
    logic [NREG*DW-1:0] SysRegs;
    logic [DW-1:0]      MapX, MapY;
    logic [1:0]         MapVal = 2'b10;
    logic               upd_sysregs;
    logic               upd_ack = 1'b0;
    logic               bot_running;

    world_if_gen #(
        .DW(DW), .NREG(NREG), .NSYS(NSYS), .WDOG_CYC(WDOG)
    ) dut (
        .clk(clk), .reset(reset), .Wr_Strobe(Wr_Strobe), .Rd_Strobe(Rd_Strobe),
        .AddrIn(AddrIn), .DataIn(DataIn), .DataOut(DataOut), .MotCtl(MotCtl),
        .BotConfig(BotConfig), .SysRegs(SysRegs), .MapX(MapX), .MapY(MapY),
        .MapVal(MapVal), .upd_sysregs(upd_sysregs), .upd_ack(upd_ack),
        .bot_running(bot_running)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
        int         due;
    } rd_t;
    rd_t exp_q[$];
    rd_t head;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare DataOut against queued read expectations, away from the edge
    always @(posedge clk) begin
        #2;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            head = exp_q.pop_front();
            check_eq($sformatf("rd_%02h", head.addr), 64'(DataOut), 64'(head.exp));
        end
    end

    // Issue a read at a negedge; the result is checked after the next posedge
    task automatic rd(input logic [7:0] a, input logic [7:0] e);
        rd_t r;
        AddrIn    = a;
        Wr_Strobe = 1'b0;
        r.addr = a;
        r.exp  = e;
        r.due  = cyc + 1;
        exp_q.push_back(r);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        AddrIn    = a;
        DataIn    = d;
        Wr_Strobe = 1'b1;
        @(negedge clk);
        Wr_Strobe = 1'b0;
    endtask

    function automatic logic [7:0] reset_read(input int a);
        case (a)
            'h00:    return 8'h5A;
            'h12:    return 8'h02;
            'h13:    return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    int ones, zeros;
    logic first_zero;

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_sysregs", 64'(SysRegs), 64'h0);
        check_eq("rst_upd", 64'(upd_sysregs), 64'h0);
        check_eq("rst_running", 64'(bot_running), 64'h0);
        check_eq("rst_dataout", 64'(DataOut), 64'h0);

        for (int a = 0; a < 32; a++) rd(8'(a), reset_read(a));
        rd(8'hE0, 8'h5A);   // upper address bits alias
        rd(8'h27, 8'h00);   // holding index beyond NREG

        // Fill holding registers and load the two groups
        for (int i = 0; i < 6; i++) wr(8'(i + 1), 8'(8'h11 * (i + 1)));
        check_eq("sys_before_load", 64'(SysRegs), 64'h0);
        wr(8'h18, 8'hFF);
        check_eq("loadsys", 64'(SysRegs), 64'h0000_4433_2211);
        wr(8'h19, 8'h00);
        check_eq("loaddist", 64'(SysRegs), 64'h6655_4433_2211);
        wr(8'h01, 8'hAA);
        check_eq("hold_no_load", 64'(SysRegs), 64'h6655_4433_2211);
        rd(8'h01, 8'hAA);
        for (int i = 1; i < 6; i++) rd(8'(i + 1), 8'(8'h11 * (i + 1)));
        rd(8'h18, 8'h00);
        wr(8'h07, 8'h99);   // unmapped holding index: ignored
        rd(8'h07, 8'h00);

        // Map address registers and read-only ports
        wr(8'h10, 8'h21);
        rd(8'h10, 8'h21);
        wr(8'h11, 8'h13);
        rd(8'h11, 8'h13);
        check_eq("mapx", 64'(MapX), 64'h21);
        check_eq("mapy", 64'(MapY), 64'h13);
        wr(8'h00, 8'h77);
        rd(8'h00, 8'h5A);

        // Update request and overrun
        wr(8'h1A, 8'h00);
        check_eq("upd_set", 64'(upd_sysregs), 64'h1);
        rd(8'h1A, 8'h01);
        repeat (3) wr(8'h1A, 8'h00);
        rd(8'h1B, 8'h03);
        AddrIn = 8'h1A; Wr_Strobe = 1'b1; upd_ack = 1'b1;
        @(negedge clk);
        Wr_Strobe = 1'b0; upd_ack = 1'b0;
        check_eq("upd_wr_ack", 64'(upd_sysregs), 64'h1);
        rd(8'h1B, 8'h03);
        upd_ack = 1'b1;
        @(negedge clk);
        upd_ack = 1'b0;
        check_eq("upd_ack", 64'(upd_sysregs), 64'h0);
        rd(8'h1A, 8'h00);
        rd(8'h1B, 8'h03);
        upd_ack = 1'b1;     // ack in IDLE does nothing
        @(negedge clk);
        upd_ack = 1'b0;
        check_eq("ack_idle", 64'(upd_sysregs), 64'h0);
        wr(8'h1B, 8'h55);
        rd(8'h1B, 8'h00);

        // Overrun saturation
        wr(8'h1A, 8'h00);
        repeat (260) wr(8'h1A, 8'h00);
        rd(8'h1B, 8'hFF);
        wr(8'h1B, 8'h00);
        rd(8'h1B, 8'h00);
        rd(8'h1A, 8'h01);

        // Single heartbeat: alive for exactly WDOG cycles
        ones = 0;
        first_zero = 1'b0;
        for (int i = 0; i < 30; i++) begin
            AddrIn    = 8'h1C;
            Wr_Strobe = (i == 0);
            #1;
            if (bot_running && !first_zero) ones++;
            if (!bot_running) first_zero = 1'b1;
            @(negedge clk);
        end
        Wr_Strobe = 1'b0;
        check_eq("wdog_alive_cycles", 64'(ones), 64'(WDOG));
        check_eq("wdog_expired", 64'(bot_running), 64'h0);
        rd(8'h1C, 8'h00);

        // Heartbeat every 10 cycles keeps it alive
        zeros = 0;
        for (int i = 0; i < 50; i++) begin
            AddrIn    = 8'h1C;
            Wr_Strobe = (i % 10 == 0);
            #1;
            if (!bot_running) zeros++;
            @(negedge clk);
        end
        Wr_Strobe = 1'b0;
        check_eq("wdog_kept_alive", 64'(zeros), 64'h0);
        rd(8'h1C, 8'h01);
        @(negedge clk);
        @(negedge clk);

        // Asynchronous reset mid-operation
        check_eq("pre_rst_upd", 64'(upd_sysregs), 64'h1);
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_sysregs", 64'(SysRegs), 64'h0);
        check_eq("arst_upd", 64'(upd_sysregs), 64'h0);
        check_eq("arst_running", 64'(bot_running), 64'h0);
        check_eq("arst_mapx", 64'(MapX), 64'h0);
        check_eq("arst_dataout", 64'(DataOut), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        rd(8'h1A, 8'h00);
        rd(8'h1B, 8'h00);
        rd(8'h02, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/world_if_gen.md
# world_if_gen

Parametrised register interface between the BOTSIM PicoBlaze and the Rojobot system logic, in the same position as the BOT 3.x world interface. It generalises the register file to NREG data registers of DW bits, split into two independently loaded groups. Load commands are single-edge copies rather than toggled levels. It adds an acknowledged update request with an overrun counter and a PicoBlaze heartbeat watchdog.

## Interface
- DW, 8: data width of all registers and of the PicoBlaze data buses
- NREG, 6: number of holding/system register pairs; legal range 2..15
- NSYS, 4: registers 0..NSYS-1 form the system group, NSYS..NREG-1 the distance group; legal range 1..NREG-1
- WDOG_CYC, 1000000: heartbeat timeout in clk cycles; must be ≥2

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- Wr_Strobe  in  1  PicoBlaze write strobe
- Rd_Strobe  in  1  PicoBlaze read strobe; no side effects, unused by decode
- AddrIn  in  8  port address; only AddrIn[4:0] decoded, upper bits alias
- DataIn  in  DW  PicoBlaze write data
- DataOut  out  DW  registered read data
- MotCtl  in  DW  motor control, read-only to PicoBlaze
- BotConfig  in  DW  BOT configuration, read-only to PicoBlaze
- SysRegs  out  NREG*DW  synchronized system registers; register i at [i*DW +: DW]
- MapX  out  DW  world map column address
- MapY  out  DW  world map row address
- MapVal  in  2  world map value at [MapY, MapX]
- upd_sysregs  out  1  update request to application, level
- upd_ack  in  1  application acknowledge, one-cycle pulse
- bot_running  out  1  high while heartbeat is alive

## Operation
Address map, A = AddrIn[4:0]:
- 0x00: read MotCtl; write ignored
- 0x01..NREG: holding register A-1, read/write
- 0x10 MapX, 0x11 MapY: read/write
- 0x12: read {0, MapVal}; write ignored
- 0x13: read BotConfig; write ignored
- 0x18 LOADSYS: write copies holding 0..NSYS-1 into SysRegs; data ignored; reads 0
- 0x19 LOADDIST: write copies holding NSYS..NREG-1 into SysRegs; data ignored; reads 0
- 0x1A UPD: write raises update request; reads {0, upd_sysregs}
- 0x1B OVR: reads overrun counter; any write clears it to 0
- 0x1C HEARTBEAT: write restarts the watchdog; reads {0, bot_running}
- All other addresses, including holding indices > NREG: read 0, write ignored

Update request, 2 states (IDLE, PEND):
- IDLE→PEND on a UPD write.
- PEND→IDLE on upd_ack with no UPD write in the same cycle.
- In PEND, a UPD write without upd_ack increments the overrun counter. The counter is DW bits and saturates at 2^DW-1. The state stays PEND.
- In PEND, a UPD write and upd_ack in the same cycle: stay PEND, no increment.
- upd_ack in IDLE is ignored.
- upd_sysregs = (state == PEND).

Watchdog:
- Down-counter loads WDOG_CYC-1 on a HEARTBEAT write.
- Otherwise it decrements each cycle and holds at 0.
- bot_running is 1 while the counter is nonzero or a HEARTBEAT write occurs in the current cycle; it is 0 otherwise.

## Timing
- Reset values: every holding register, every SysRegs field, MapX, MapY, DataOut, overrun counter and watchdog counter reset to 0; state resets to IDLE.
- Consequently, after reset upd_sysregs=0 and bot_running=0.
- Writes take effect at the rising edge where Wr_Strobe=1.
- LOADSYS/LOADDIST: SysRegs fields show the holding values present before that edge, immediately after the edge (latency 1 edge). Other fields are unchanged.
- UPD: upd_sysregs high after the same edge. It drops after the edge sampling upd_ack.
- DataOut: registered from AddrIn every cycle (1-cycle read latency), independent of Rd_Strobe. A read the cycle after a write returns the new value.
- Overrun increment and OVR clear in the same edge: clear wins.
- Reset asserted mid-operation forces all reset values asynchronously. A pending request is lost; no acknowledge is required.

## Test plan
- Reset, then read every address 0x00..0x1F → 0 except MotCtl, BotConfig and MapVal echoes; SysRegs=0, upd_sysregs=0, bot_running=0.
- Write holding 0..5 with 0x11..0x66, then LOADSYS → SysRegs fields 0..3 = 0x11..0x44 one edge later, fields 4..5 still 0. LOADDIST → fields 4..5 = 0x55, 0x66.
- Write holding 0 = 0xAA without a load → SysRegs field 0 unchanged; read port 0x01 → 0xAA.
- UPD write → upd_sysregs=1. Three more UPD writes with no ack → OVR reads 3. UPD write with simultaneous upd_ack → upd_sysregs stays 1, OVR still 3. Ack alone → 0. OVR write → reads 0.
- WDOG_CYC=16: HEARTBEAT write → bot_running=1 for exactly 16 cycles then 0. Heartbeats every 10 cycles keep it at 1 continuously.
- Assert reset while upd_sysregs=1 and SysRegs nonzero → all outputs 0 without waiting for a clock edge.
